pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'd0, PC value loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 32'd1, word-addressed increment per accepted fetch.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  level; blocks issue of a new fetch.
REQ-006 halt  in  1  level; stops fetching, enters HALTED.
REQ-007 redirect_valid  in  1  branch/jump taken this cycle.
REQ-008 redirect_target  in  32  new PC on redirect.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 imem_addr  out  32  fetch address; registered, stable while imem_req=1.
REQ-011 imem_ack  in  1  memory accepts and returns data this cycle; ignored when imem_req=0.
REQ-012 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-013 insn_valid  out  1  one-cycle pulse, delivered instruction.
REQ-014 insn  out  32  delivered instruction word, held between pulses.
REQ-015 insn_pc  out  32  address of the delivered instruction, held between pulses.
REQ-016 pc_current  out  32  architectural PC register.
REQ-017 halted  out  1  high while in HALTED.

Function
REQ-018 SHALL implement states IDLE, REQ and HALTED; imem_req=1 iff state=REQ; halted=1 iff state=HALTED.
REQ-019 Priority per cycle SHALL be reset > redirect > ack handling > halt > stall.
REQ-020 IDLE, no redirect: halt=1 -> HALTED; else stall=0 -> REQ with imem_addr<=pc_current; else stay.
REQ-021 IDLE or HALTED with redirect_valid=1: pc_current<=redirect_target, next state IDLE.
REQ-022 REQ SHALL hold imem_req=1 and imem_addr constant until imem_ack=1, regardless of stall/halt.
REQ-023 REQ, imem_ack=1, kill=0, no redirect (accepted): next cycle insn_valid=1, insn=imem_rdata, insn_pc=imem_addr; pc_current<=pc_current+PC_STEP (mod 2^32).
REQ-024 On accepted ack: halt=1 -> HALTED; else stall=1 -> IDLE; else stay REQ with imem_addr<=pc_current+PC_STEP (back-to-back, 1 insn/cycle with zero-wait memory).
REQ-025 REQ, redirect_valid=1, imem_ack=0: pc_current<=redirect_target, kill<=1, stay REQ with imem_addr unchanged.
REQ-026 REQ, redirect_valid=1, imem_ack=1: data discarded (no insn_valid), pc_current<=redirect_target, kill<=0, -> IDLE.
REQ-027 REQ, imem_ack=1, kill=1, no redirect: data discarded, kill<=0, pc_current unchanged, -> IDLE.
REQ-028 Redirect in REQ while kill=1 and no ack: pc_current<=new redirect_target, kill stays 1 (last redirect wins).
REQ-029 insn_valid SHALL be 0 in every cycle not directly following an accepted ack.
REQ-030 pc_current SHALL wrap 32'hFFFFFFFF+PC_STEP modulo 2^32 without flag.
REQ-031 HALTED SHALL be left only by redirect (-> IDLE) or reset.

Reset
REQ-032 reset=1 at a rising edge: state IDLE, pc_current=RESET_PC, imem_addr=RESET_PC, kill=0, imem_req=0, insn_valid=0, insn=0, insn_pc=0, halted=0.
REQ-033 Reset during REQ SHALL abandon the outstanding request; ack in the reset cycle is ignored.
REQ-034 First request SHALL issue no earlier than the second edge after reset deasserts (IDLE->REQ).

Verification
REQ-035 Reset, stall=0, imem_ack tied 1, rdata=addr+100 -> insn_valid every cycle from 3rd edge, insn_pc 0,1,2,..., insn 100,101,102.
REQ-036 imem_ack delayed 3 cycles, stall toggled during wait -> imem_req and imem_addr held constant, single insn_valid after ack.
REQ-037 Redirect to 0x40 while REQ waits on addr 5, ack 2 cycles later -> no insn_valid for addr 5, next request addr 0x40, insn_pc 0x40.
REQ-038 Redirect to 0x80 in same cycle as ack -> data discarded, pc_current=0x80, state IDLE then REQ at 0x80.
REQ-039 halt=1 with ack on addr 7 -> insn_pc=7 delivered, halted=1, pc_current=8, no further imem_req; redirect to 0x10 -> halted=0, fetch resumes at 0x10.
REQ-040 pc_current=0xFFFFFFFF, accepted ack -> pc_current=0, next imem_addr=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter fetch sequencer: issues word fetches, tracks redirects and
// squashes the in-flight fetch when a redirect overtakes it.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_insn_valid,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  output logic [31:0] o_pc_current,
  output logic        o_halted
);

  // state  | meaning
  // IDLE   | no fetch outstanding, waiting for stall/halt to clear
  // REQ    | fetch outstanding at r_addr, held until ack
  // HALTED | fetching stopped, only a redirect or reset leaves
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_kill;
  logic        r_insn_valid;
  logic [31:0] r_insn;
  logic [31:0] r_insn_pc;
  logic [31:0] w_pc_next;

  assign w_pc_next = r_pc + PC_STEP;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_kill       <= 1'b0;
      r_insn_valid <= 1'b0;
      r_insn       <= 32'd0;
      r_insn_pc    <= 32'd0;
    end else begin
      r_insn_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_redirect_valid) begin
            r_pc <= i_redirect_target;
          end else if (i_halt) begin
            r_state <= S_HALTED;
          end else if (!i_stall) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        S_REQ: begin
          // A redirect without ack leaves the old request on the bus but marks
          // its eventual data as stale.
          if (i_redirect_valid) begin
            r_pc <= i_redirect_target;
            if (i_imem_ack) begin
              r_kill  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (i_imem_ack) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_insn_valid <= 1'b1;
              r_insn       <= i_imem_rdata;
              r_insn_pc    <= r_addr;
              r_pc         <= w_pc_next;
              if (i_halt) begin
                r_state <= S_HALTED;
              end else if (i_stall) begin
                r_state <= S_IDLE;
              end else begin
                r_addr <= w_pc_next;
              end
            end
          end
        end
        S_HALTED: begin
          if (i_redirect_valid) begin
            r_pc    <= i_redirect_target;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_imem_req   = (r_state == S_REQ);
  assign o_imem_addr  = r_addr;
  assign o_insn_valid = r_insn_valid;
  assign o_insn       = r_insn;
  assign o_insn_pc    = r_insn_pc;
  assign o_pc_current = r_pc;
  assign o_halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: streaming, wait states, redirects, halt, wrap.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, halt, rv, ack;
  logic [31:0] rt, rdata;
  logic        req, ivalid, halted;
  logic [31:0] addr, insn, ipc, pc;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_halt(halt),
    .i_redirect_valid(rv), .i_redirect_target(rt),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_insn_valid(ivalid), .o_insn(insn), .o_insn_pc(ipc),
    .o_pc_current(pc), .o_halted(halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; halt = 1'b0; rv = 1'b0; rt = 32'd0; ack = 1'b0; rdata = 32'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", req); end
    total++; if (addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr); end
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ivalid); end
    total++; if (insn !== 32'd0 || ipc !== 32'd0) begin bad++; $display("FAIL reset_insn got=%h/%h exp=0/0", insn, ipc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_stream();
    do_reset();
    ack = 1'b1;
    tick();
    total++; if (req !== 1'b1 || addr !== 32'd0 || ivalid !== 1'b0) begin bad++; $display("FAIL stream_first_req got=%b/%h/%b exp=1/0/0", req, addr, ivalid); end
    rdata = addr + 32'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (ivalid !== 1'b1 || ipc !== 32'(i) || insn !== 32'(100 + i) || pc !== 32'(i + 1))
        begin bad++; $display("FAIL stream_%0d got v=%b pc=%h insn=%h cur=%h exp v=1 pc=%h insn=%h cur=%h", i, ivalid, ipc, insn, pc, i, 100 + i, i + 1); end
      rdata = addr + 32'd100;
    end
    ack = 1'b0;
    tick();
    total++; if (ivalid !== 1'b0 || addr !== 32'd5) begin bad++; $display("FAIL stream_stop got=%b/%h exp=0/5", ivalid, addr); end
  endtask

  task automatic test_wait_states();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = (i % 2 == 0);
      tick();
      total++; if (req !== 1'b1 || addr !== 32'd0 || ivalid !== 1'b0) begin bad++; $display("FAIL wait_hold_%0d got=%b/%h/%b exp=1/0/0", i, req, addr, ivalid); end
    end
    ack = 1'b1; rdata = 32'hDEAD_BEEF; stall = 1'b1;
    tick();
    total++; if (ivalid !== 1'b1 || insn !== 32'hDEAD_BEEF || ipc !== 32'd0 || req !== 1'b0) begin bad++; $display("FAIL wait_ack got=%b/%h/%h/%b exp=1/deadbeef/0/0", ivalid, insn, ipc, req); end
    ack = 1'b0;
    tick();
    total++; if (ivalid !== 1'b0 || req !== 1'b0 || pc !== 32'd1) begin bad++; $display("FAIL wait_single got=%b/%b/%h exp=0/0/1", ivalid, req, pc); end
    stall = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    ack = 1'b1;
    tick();
    repeat (5) tick();
    ack = 1'b0;
    total++; if (addr !== 32'd5 || req !== 1'b1) begin bad++; $display("FAIL redir_setup got=%h/%b exp=5/1", addr, req); end
    rv = 1'b1; rt = 32'h40;
    tick();
    rv = 1'b0;
    total++; if (pc !== 32'h40 || addr !== 32'd5 || req !== 1'b1) begin bad++; $display("FAIL redir_hold got=%h/%h/%b exp=40/5/1", pc, addr, req); end
    tick();
    ack = 1'b1; rdata = 32'h5555;
    tick();
    ack = 1'b0;
    total++; if (ivalid !== 1'b0 || req !== 1'b0 || pc !== 32'h40) begin bad++; $display("FAIL redir_kill got=%b/%b/%h exp=0/0/40", ivalid, req, pc); end
    tick();
    total++; if (req !== 1'b1 || addr !== 32'h40) begin bad++; $display("FAIL redir_newreq got=%b/%h exp=1/40", req, addr); end
    ack = 1'b1; rdata = 32'h1234;
    tick();
    ack = 1'b0;
    total++; if (ivalid !== 1'b1 || ipc !== 32'h40 || insn !== 32'h1234) begin bad++; $display("FAIL redir_deliver got=%b/%h/%h exp=1/40/1234", ivalid, ipc, insn); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    tick();
    ack = 1'b1; rdata = 32'h9999; rv = 1'b1; rt = 32'h80;
    tick();
    ack = 1'b0; rv = 1'b0;
    total++; if (ivalid !== 1'b0 || pc !== 32'h80 || req !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL rack_discard got=%b/%h/%b exp=0/80/0", ivalid, pc, req); end
    tick();
    total++; if (req !== 1'b1 || addr !== 32'h80) begin bad++; $display("FAIL rack_req got=%b/%h exp=1/80", req, addr); end
  endtask

  task automatic test_halt();
    do_reset();
    rv = 1'b1; rt = 32'd7;
    tick();
    rv = 1'b0;
    tick();
    total++; if (req !== 1'b1 || addr !== 32'd7) begin bad++; $display("FAIL halt_setup got=%b/%h exp=1/7", req, addr); end
    halt = 1'b1; ack = 1'b1; rdata = 32'h77;
    tick();
    ack = 1'b0;
    total++; if (ivalid !== 1'b1 || ipc !== 32'd7 || halted !== 1'b1 || pc !== 32'd8 || req !== 1'b0) begin bad++; $display("FAIL halt_deliver got=%b/%h/%b/%h/%b exp=1/7/1/8/0", ivalid, ipc, halted, pc, req); end
    halt = 1'b0;
    repeat (2) tick();
    total++; if (req !== 1'b0 || halted !== 1'b1 || ivalid !== 1'b0) begin bad++; $display("FAIL halt_stay got=%b/%b/%b exp=0/1/0", req, halted, ivalid); end
    rv = 1'b1; rt = 32'h10;
    tick();
    rv = 1'b0;
    total++; if (halted !== 1'b0 || pc !== 32'h10 || req !== 1'b0) begin bad++; $display("FAIL halt_exit got=%b/%h/%b exp=0/10/0", halted, pc, req); end
    tick();
    total++; if (req !== 1'b1 || addr !== 32'h10) begin bad++; $display("FAIL halt_resume got=%b/%h exp=1/10", req, addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    rv = 1'b1; rt = 32'hFFFF_FFFF;
    tick();
    rv = 1'b0;
    tick();
    ack = 1'b1; rdata = 32'hABCD;
    tick();
    ack = 1'b0;
    total++; if (ivalid !== 1'b1 || ipc !== 32'hFFFF_FFFF || pc !== 32'd0 || addr !== 32'd0 || req !== 1'b1) begin bad++; $display("FAIL wrap got=%b/%h/%h/%h/%b exp=1/ffffffff/0/0/1", ivalid, ipc, pc, addr, req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rv = 1'b1; rt = 32'h33;
    tick();
    rv = 1'b0;
    tick();
    rst = 1'b1; ack = 1'b1; rdata = 32'h4242;
    tick();
    rst = 1'b0; ack = 1'b0;
    total++; if (req !== 1'b0 || ivalid !== 1'b0 || pc !== 32'd0 || addr !== 32'd0 || insn !== 32'd0) begin bad++; $display("FAIL reset_mid got=%b/%b/%h/%h/%h exp=0/0/0/0/0", req, ivalid, pc, addr, insn); end
    tick();
    total++; if (req !== 1'b1 || addr !== 32'd0) begin bad++; $display("FAIL reset_mid_restart got=%b/%h exp=1/0", req, addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_redirect_wait();
    test_redirect_ack();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
